// File: rtl/shift_seq.sv
// Multi-cycle barrel shifter: one log2 stage per cycle (1, 2, 4, 8, 16).
// Optional build macro SHIFT_SEQ_EARLY_EXIT_EN stops as soon as the remaining shamt bits are zero.
module shift_seq #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result
);

    // state | meaning
    // IDLE  | waiting for start; result holds the previous answer
    // SHIFT | applying stage 2**k when the latched shamt[k] is set
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [2:0] K_LAST = 3'(SHAMT_W - 1);

    state_t             state_q, state_nxt;
    logic [2:0]         k_q, k_nxt;
    logic [1:0]         op_q, op_nxt;
    logic [SHAMT_W-1:0] shamt_q, shamt_nxt;
    logic [DATA_W-1:0]  result_q, result_nxt;
    logic [SHAMT_W-1:0] stage_amt;
    logic [DATA_W-1:0]  stage_val;
    logic               upper_zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= 3'd0;
            op_q     <= 2'b00;
            shamt_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_nxt;
            k_q      <= k_nxt;
            op_q     <= op_nxt;
            shamt_q  <= shamt_nxt;
            result_q <= result_nxt;
        end
    end

    // Stage value for the current k; SRA replicates the sign of the partially shifted value.
    always_comb begin
        stage_amt = SHAMT_W'(1) << k_q;
        case (op_q)
            OP_SLL:  stage_val = result_q << stage_amt;
            OP_SRL:  stage_val = result_q >> stage_amt;
            OP_SRA:  stage_val = DATA_W'($signed(result_q) >>> stage_amt);
            default: stage_val = result_q;
        endcase
        upper_zero = ((shamt_q >> k_q) >> 1) == '0;
    end

    always_comb begin
        state_nxt  = state_q;
        k_nxt      = k_q;
        op_nxt     = op_q;
        shamt_nxt  = shamt_q;
        result_nxt = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_nxt     = op;
                    shamt_nxt  = shamt;
                    result_nxt = a;
                    k_nxt      = 3'd0;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                    state_nxt  = (shamt == '0) ? DONE : SHIFT;
`else
                    state_nxt  = SHIFT;
`endif
                end
            end
            SHIFT: begin
                if (shamt_q[k_q]) begin
                    result_nxt = stage_val;
                end
                k_nxt = k_q + 3'd1;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                if (k_q == K_LAST || upper_zero) begin
                    state_nxt = DONE;
                end
`else
                if (k_q == K_LAST) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
                k_nxt     = 3'd0;
            end
            default: begin
                state_nxt = IDLE;
                k_nxt     = 3'd0;
            end
        endcase
    end

`ifndef SHIFT_SEQ_EARLY_EXIT_EN
    // Only consumed by the early-exit path.
    logic unused_ok;
    assign unused_ok = upper_zero;
`endif

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule
